// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared screen geometry, widths and colour constants for the framebuffer probe
package fb_pkg;
    localparam int SCR_W     = 320;
    localparam int SCR_H     = 240;
    localparam int BOX_BITS  = 5;
    localparam int COL_W     = 3;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int ADDR_W    = 17;
    localparam int CNT_W     = 10;
    localparam int RAM_DEPTH = SCR_W * SCR_H;

    typedef logic [COL_W-1:0] colour_t;

    localparam colour_t BLACK  = 3'b000;
    localparam colour_t BULLET = 3'b101;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(SCR_W) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/fb_pixel_probe_if.sv
// rtl/fb_pixel_probe_if.sv - pixel-write snoop, box query and result handshake bundle
// PROBE_HIT_COUNT_EN adds the r_count result field.
interface fb_pixel_probe_if
    import fb_pkg::*;
;
    logic                wr_plot;
    logic [X_W-1:0]      wr_x;
    logic [Y_W-1:0]      wr_y;
    colour_t             wr_colour;

    logic                q_valid;
    logic                q_ready;
    logic [X_W-1:0]      q_x;
    logic [Y_W-1:0]      q_y;
    logic [BOX_BITS-1:0] q_w;
    logic [BOX_BITS-1:0] q_h;
    colour_t             q_colour;

    logic                r_valid;
    logic                r_ready;
    logic                r_hit;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
`ifdef PROBE_HIT_COUNT_EN
    logic [CNT_W-1:0]    r_count;

    modport master (
        output wr_plot, wr_x, wr_y, wr_colour,
        output q_valid, q_x, q_y, q_w, q_h, q_colour,
        input  q_ready,
        output r_ready,
        input  r_valid, r_hit, r_x, r_y, r_count
    );

    modport slave (
        input  wr_plot, wr_x, wr_y, wr_colour,
        input  q_valid, q_x, q_y, q_w, q_h, q_colour,
        output q_ready,
        input  r_ready,
        output r_valid, r_hit, r_x, r_y, r_count
    );
`else
    modport master (
        output wr_plot, wr_x, wr_y, wr_colour,
        output q_valid, q_x, q_y, q_w, q_h, q_colour,
        input  q_ready,
        output r_ready,
        input  r_valid, r_hit, r_x, r_y
    );

    modport slave (
        input  wr_plot, wr_x, wr_y, wr_colour,
        input  q_valid, q_x, q_y, q_w, q_h, q_colour,
        output q_ready,
        input  r_ready,
        output r_valid, r_hit, r_x, r_y
    );
`endif
endinterface

// File: rtl/fb_shadow_ram.sv
// rtl/fb_shadow_ram.sv - single-port 76800x3 shadow framebuffer, synchronous read, write wins
module fb_shadow_ram
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  colour_t           wdata,
    output colour_t           rdata
);
    colour_t mem [RAM_DEPTH];
    colour_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fb_pixel_probe.sv
// rtl/fb_pixel_probe.sv - snoops plotted pixels into a shadow framebuffer and answers colour-in-box queries
// PROBE_HIT_COUNT_EN: scan whole box and report the number of matching pixels on r_count.
module fb_pixel_probe
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    fb_pixel_probe_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [X_W-1:0]      bx_q, bx_d;
    logic [Y_W-1:0]      by_q, by_d;
    logic [BOX_BITS-1:0] bw_q, bw_d, bh_q, bh_d;
    logic [BOX_BITS-1:0] cx_q, cx_d, cy_q, cy_d;
    colour_t             col_q, col_d;
    logic                cmp_v_q, cmp_v_d;
    logic [X_W-1:0]      cmp_x_q, cmp_x_d;
    logic [Y_W-1:0]      cmp_y_q, cmp_y_d;
    logic                hit_q, hit_d;
    logic [X_W-1:0]      rx_q, rx_d;
    logic [Y_W-1:0]      ry_q, ry_d;
`ifdef PROBE_HIT_COUNT_EN
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic        wr_ok;
    logic [9:0]  px, py;
    logic        on_screen;
    logic        rd_en;
    logic        advance;
    logic        last_x, last_y;
    logic        match;
    colour_t     rd_data;

    assign wr_ok = bus.wr_plot && (bus.wr_x < X_W'(SCR_W)) && (bus.wr_y < Y_W'(SCR_H));

    // 10-bit sums so a box hanging off the right/bottom edge never wraps back on-screen
    assign px        = {1'b0, bx_q} + 10'(cx_q);
    assign py        = {2'b0, by_q} + 10'(cy_q);
    assign on_screen = (px < 10'(SCR_W)) && (py < 10'(SCR_H));
    assign last_x    = (cx_q == bw_q - BOX_BITS'(1));
    assign last_y    = (cy_q == bh_q - BOX_BITS'(1));

    // A pending write steals the single RAM port; off-screen pixels never need it
    assign advance = !(on_screen && wr_ok);
    assign rd_en   = (state_q == ST_SCAN) && on_screen && !wr_ok;
    assign match   = cmp_v_q && (rd_data == col_q) &&
                     ((state_q == ST_SCAN) || (state_q == ST_DRAIN));

    fb_shadow_ram u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .re    (rd_en),
        .addr  (wr_ok ? pix_addr(bus.wr_x, bus.wr_y) : pix_addr(px[X_W-1:0], py[Y_W-1:0])),
        .wdata (bus.wr_colour),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bw_d    = bw_q;
        bh_d    = bh_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        cmp_v_d = rd_en;
        cmp_x_d = px[X_W-1:0];
        cmp_y_d = py[Y_W-1:0];
        hit_d   = hit_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
`ifdef PROBE_HIT_COUNT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.q_valid) begin
                    bx_d  = bus.q_x;
                    by_d  = bus.q_y;
                    bw_d  = bus.q_w;
                    bh_d  = bus.q_h;
                    col_d = bus.q_colour;
                    cx_d  = '0;
                    cy_d  = '0;
                    hit_d = 1'b0;
                    rx_d  = '0;
                    ry_d  = '0;
`ifdef PROBE_HIT_COUNT_EN
                    cnt_d = '0;
`endif
                    state_d = (bus.q_w == '0 || bus.q_h == '0) ? ST_RESP : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (advance) begin
                    if (last_x) begin
                        cx_d = '0;
                        if (last_y) begin
                            state_d = ST_DRAIN;
                        end else begin
                            cy_d = cy_q + BOX_BITS'(1);
                        end
                    end else begin
                        cx_d = cx_q + BOX_BITS'(1);
                    end
                end
            end
            ST_DRAIN: state_d = ST_RESP;
            default: begin
                if (bus.r_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (match) begin
            if (!hit_q) begin
                hit_d = 1'b1;
                rx_d  = cmp_x_q;
                ry_d  = cmp_y_q;
            end
`ifdef PROBE_HIT_COUNT_EN
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`else
            state_d = ST_RESP;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            cmp_v_q <= 1'b0;
            cmp_x_q <= '0;
            cmp_y_q <= '0;
            hit_q   <= 1'b0;
            rx_q    <= '0;
            ry_q    <= '0;
`ifdef PROBE_HIT_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bw_q    <= bw_d;
            bh_q    <= bh_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            cmp_v_q <= cmp_v_d;
            cmp_x_q <= cmp_x_d;
            cmp_y_q <= cmp_y_d;
            hit_q   <= hit_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
`ifdef PROBE_HIT_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.q_ready = (state_q == ST_IDLE);
    assign bus.r_valid = (state_q == ST_RESP);
    assign bus.r_hit   = hit_q;
    assign bus.r_x     = rx_q;
    assign bus.r_y     = ry_q;
`ifdef PROBE_HIT_COUNT_EN
    assign bus.r_count = cnt_q;
`endif
endmodule

// File: tb/tb_fb_pixel_probe.sv
// tb/tb_fb_pixel_probe.sv - scoreboard bench for fb_pixel_probe with directed box queries
// PROBE_HIT_COUNT_EN switches expectations to whole-box scans with r_count.
module tb_fb_pixel_probe;
    import fb_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fb_pixel_probe_if bus();

    fb_pixel_probe dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        string name;
        bit    hit;
        int    x;
        int    y;
        int    lat;
        int    cnt;
        int    acc;
    } exp_t;

    exp_t sbq[$];
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int lat_of(input bit hit, input int k, input int n);
        int l;
`ifdef PROBE_HIT_COUNT_EN
        l = n + 2;
        if (hit && k < 0) l = 0;
`else
        l = hit ? k + 3 : n + 2;
`endif
        return l;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && bus.r_valid && bus.r_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", int'(bus.r_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_hit"}, int'(bus.r_hit), int'(e.hit));
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                    if (e.hit) begin
                        chk({e.name, "_x"}, int'(bus.r_x), e.x);
                        chk({e.name, "_y"}, int'(bus.r_y), e.y);
                    end
`ifdef PROBE_HIT_COUNT_EN
                    chk({e.name, "_count"}, int'(bus.r_count), e.cnt);
`endif
                end
            end
        end
    endtask

    task automatic write_pix(input int x, input int y, input colour_t c);
        bus.wr_plot   = 1'b1;
        bus.wr_x      = 9'(x);
        bus.wr_y      = 8'(y);
        bus.wr_colour = c;
        @(negedge clk);
        bus.wr_plot   = 1'b0;
    endtask

    task automatic query(input string name, input int x, input int y, input int w, input int h,
                         input colour_t c, input bit push, input bit hit, input int ex,
                         input int ey, input int lat, input int cnt);
        exp_t e;
        int   t;
        t = 0;
        while (!bus.q_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_q_ready"}, int'(bus.q_ready), 1);
        bus.q_x      = 9'(x);
        bus.q_y      = 8'(y);
        bus.q_w      = BOX_BITS'(w);
        bus.q_h      = BOX_BITS'(h);
        bus.q_colour = c;
        bus.q_valid  = 1'b1;
        if (push) begin
            e.name = name;
            e.hit  = hit;
            e.x    = ex;
            e.y    = ey;
            e.lat  = lat;
            e.cnt  = cnt;
            e.acc  = cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.q_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_pending"}, sbq.size(), 0);
        sbq.delete();
        @(negedge clk);
    endtask

    initial begin
        bus.wr_plot   = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_colour = '0;
        bus.q_valid   = 1'b0;
        bus.q_x       = '0;
        bus.q_y       = '0;
        bus.q_w       = '0;
        bus.q_h       = '0;
        bus.q_colour  = '0;
        bus.r_ready   = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_q_ready", int'(bus.q_ready), 1);
        chk("rst_r_valid", int'(bus.r_valid), 0);
        chk("rst_r_hit",   int'(bus.r_hit),   0);
        chk("rst_r_x",     int'(bus.r_x),     0);
        chk("rst_r_y",     int'(bus.r_y),     0);
        resetn = 1'b1;
        @(negedge clk);

        write_pix(12, 11, BULLET);
        query("single_hit", 10, 10, 4, 4, BULLET, 1, 1, 12, 11, lat_of(1, 6, 16), 1);
        wait_done("single_hit");

        query("empty_miss", 0, 0, 3, 2, BULLET, 1, 0, 0, 0, lat_of(0, 0, 6), 0);
        wait_done("empty_miss");

        query("zero_width", 0, 0, 0, 4, BULLET, 1, 0, 0, 0, 1, 0);
        wait_done("zero_width");
        query("zero_height", 5, 5, 3, 0, BLACK, 1, 0, 0, 0, 1, 0);
        wait_done("zero_height");

        query("corner_black", 318, 238, 4, 4, BLACK, 1, 1, 318, 238, lat_of(1, 0, 16), 4);
        wait_done("corner_black");
        write_pix(318, 238, 3'b010);
        write_pix(319, 238, 3'b010);
        write_pix(318, 239, 3'b010);
        write_pix(319, 239, 3'b010);
        query("corner_miss", 318, 238, 4, 4, BLACK, 1, 0, 0, 0, lat_of(0, 0, 16), 0);
        wait_done("corner_miss");

        write_pix(320, 5, BULLET);
        write_pix(5, 240, BULLET);
        query("oor_dropped", 0, 6, 1, 1, BULLET, 1, 0, 0, 0, lat_of(0, 0, 1), 0);
        wait_done("oor_dropped");
        query("oor_black", 0, 6, 1, 1, BLACK, 1, 1, 0, 6, lat_of(1, 0, 1), 1);
        wait_done("oor_black");

        write_pix(203, 50, 3'b011);
        write_pix(201, 51, 3'b011);
        write_pix(200, 52, 3'b011);
        write_pix(201, 52, 3'b011);
        write_pix(203, 53, 3'b011);
        query("multi_match", 200, 50, 4, 4, 3'b011, 1, 1, 203, 50, lat_of(1, 3, 16), 5);
        wait_done("multi_match");

        query("write_stall", 100, 100, 4, 4, BULLET, 1, 1, 102, 101, lat_of(1, 6, 16) + 3, 1);
        repeat (2) @(negedge clk);
        bus.wr_plot   = 1'b1;
        bus.wr_x      = 9'd102;
        bus.wr_y      = 8'd101;
        bus.wr_colour = BULLET;
        repeat (3) @(negedge clk);
        bus.wr_plot   = 1'b0;
        wait_done("write_stall");

        query("aborted", 150, 150, 8, 8, BULLET, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("abort_busy_q_ready", int'(bus.q_ready), 0);
        resetn = 1'b0;
        #1;
        chk("abort_q_ready", int'(bus.q_ready), 1);
        chk("abort_r_valid", int'(bus.r_valid), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        query("after_reset", 150, 150, 8, 8, BLACK, 1, 1, 150, 150, lat_of(1, 0, 64), 64);
        wait_done("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
